// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_pkg
// Purpose  : Shared constants, types and helpers for the encoder arbiter.
//            - ENC_TDATA_W : width of one encoder count beat
//            - DEF_N_CH / DEF_CNT_W : default channel count / counter width
//            - ch_id_w()   : width of a channel index (clog2, minimum 1)
//            - out_state_e : output register occupancy
// Revision : 1.0 - initial release
// ============================================================================
package enc_pkg;

  localparam int ENC_TDATA_W = 64;
  localparam int DEF_N_CH    = 4;
  localparam int DEF_CNT_W   = 32;

  function automatic int ch_id_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage
`default_nettype wire

// File: rtl/enc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : enc_rr_arb
// Purpose  : Combinational round-robin selector. Finds the first requesting
//            channel searching upward from (last_grant+1) modulo N_CH.
// Ports    : request     in  N_CH  requesting channels
//            last_grant  in  ID_W  most recently granted channel
//            enable      in  1     grant allowed this cycle
//            grant_valid out 1     a channel is granted
//            grant_idx   out ID_W  granted channel index
// Revision : 1.0 - initial release
// ============================================================================
module enc_rr_arb
  import enc_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int ID_W = ch_id_w(N_CH)
) (
  input  logic [N_CH-1:0] request,
  input  logic [ID_W-1:0] last_grant,
  input  logic            enable,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_idx
);

  logic            found;
  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Offsets 1..N_CH visit every channel once, ending on last_grant itself,
  // so a lone requester is always served even if it was granted last.
  always_comb begin
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    grant_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      cand_idx = ID_W'(cand);
      if (!found && request[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
    grant_valid = enable & found;
  end

endmodule
`default_nettype wire

// File: rtl/enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : enc_arbiter
// Purpose  : Merges N_CH encoder count streams into one AXI-Stream towards
//            the packetizer through a single-entry output register, with
//            round-robin fairness and per-channel accepted-event counters.
// Ports    : clk, areset (async, active-high)
//            s_axis_tdata/tuser/tvalid/tready : per-channel input streams
//            ch_enable  : per-channel grant enable mask
//            cnt_clear  : synchronous clear of all event counters
//            m_axis_tdata/tuser/tvalid/tready/tlast/tid : merged stream
//            ev_count   : accepted-event counters, channel i at slice i
// Revision : 1.0 - initial release
// ============================================================================
module enc_arbiter
  import enc_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [N_CH*ENC_TDATA_W-1:0]   s_axis_tdata,
  input  logic [N_CH-1:0]               s_axis_tuser,
  input  logic [N_CH-1:0]               s_axis_tvalid,
  output logic [N_CH-1:0]               s_axis_tready,
  input  logic [N_CH-1:0]               ch_enable,
  input  logic                          cnt_clear,
  output logic [ENC_TDATA_W-1:0]        m_axis_tdata,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ch_id_w(N_CH)-1:0]      m_axis_tid,
  output logic [N_CH*CNT_W-1:0]         ev_count
);

  localparam int ID_W = ch_id_w(N_CH);

  out_state_e            state, state_next;
  logic                  load_en;
  logic                  grant_valid;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       last_grant;
  logic [N_CH-1:0]       eligible;
  logic [N_CH-1:0]       accept;
  logic [ENC_TDATA_W-1:0] data_q;
  logic                  user_q;
  logic [ID_W-1:0]       tid_q;

  assign eligible = s_axis_tvalid & ch_enable;
  assign load_en  = (state == OUT_EMPTY) || m_axis_tready;

  // Grants are suppressed while reset is held so no input beat is consumed.
  enc_rr_arb #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_rr_arb (
    .request     (eligible),
    .last_grant  (last_grant),
    .enable      (load_en & ~areset),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    accept = '0;
    if (grant_valid) begin
      accept[grant_idx] = 1'b1;
    end
  end

  assign s_axis_tready = accept;

  // Output register occupancy
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (load_en) begin
      state_next = grant_valid ? OUT_FULL : OUT_EMPTY;
    end
  end

  // Beat capture; contents only change on an accepted grant, so a stalled
  // FULL register holds every output stable.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      data_q     <= '0;
      user_q     <= 1'b0;
      tid_q      <= '0;
      last_grant <= ID_W'(N_CH - 1);
    end else if (grant_valid) begin
      data_q     <= s_axis_tdata[grant_idx*ENC_TDATA_W +: ENC_TDATA_W];
      user_q     <= s_axis_tuser[grant_idx];
      tid_q      <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  assign m_axis_tvalid = (state == OUT_FULL);
  assign m_axis_tlast  = m_axis_tvalid;
  assign m_axis_tdata  = data_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tid    = tid_q;

  // Accepted-event counters; clear takes priority over a coincident accept.
  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
          cnt_q <= '0;
        end else if (cnt_clear) begin
          cnt_q <= '0;
        end else if (accept[i]) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign ev_count[i*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_arbiter
// Purpose  : Self-checking bench for enc_arbiter: a table of per-cycle
//            vectors plus hand sequences for stall, clear, reset and counter
//            wrap (the wrap uses a narrow-counter instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_arbiter;
  import enc_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 32;

  logic                clk = 1'b0;
  logic                areset;
  logic [NCH*64-1:0]   s_tdata;
  logic [NCH-1:0]      s_tuser, s_tvalid, s_tready, ch_en;
  logic                cnt_clear;
  logic [63:0]         m_tdata;
  logic                m_tuser, m_tvalid, m_tready, m_tlast;
  logic [1:0]          m_tid;
  logic [NCH*CW-1:0]   ev_count;

  // Narrow instance: 2 channels, 4-bit counters
  logic [127:0]        w_tdata;
  logic [1:0]          w_tuser, w_tvalid, w_tready, w_en;
  logic                w_clear, w_mready;
  logic [63:0]         w_mdata;
  logic                w_muser, w_mvalid, w_mlast;
  logic [0:0]          w_mtid;
  logic [7:0]          w_count;

  int n_chk  = 0;
  int n_fail = 0;
  int n_deliv = 0;
  logic [3:0] tuser_pat;

  always #5 clk = ~clk;

  enc_arbiter #(.N_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .ch_enable(ch_en), .cnt_clear(cnt_clear),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .ev_count(ev_count)
  );

  enc_arbiter #(.N_CH(2), .CNT_W(4)) dut_w (
    .clk(clk), .areset(areset),
    .s_axis_tdata(w_tdata), .s_axis_tuser(w_tuser),
    .s_axis_tvalid(w_tvalid), .s_axis_tready(w_tready),
    .ch_enable(w_en), .cnt_clear(w_clear),
    .m_axis_tdata(w_mdata), .m_axis_tuser(w_muser),
    .m_axis_tvalid(w_mvalid), .m_axis_tready(w_mready),
    .m_axis_tlast(w_mlast), .m_axis_tid(w_mtid), .ev_count(w_count)
  );

  always @(posedge clk) begin
    if (!areset && m_tvalid && m_tready) n_deliv++;
  end

  function automatic logic [63:0] ch_data(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h0000_BEE0 + 32'(i)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return ev_count[i*CW +: CW];
  endfunction

  typedef struct {
    logic [3:0] valid;
    logic [3:0] en;
    logic       mready;
    logic [3:0] exp_sready;
    logic       exp_mvalid;
    logic [1:0] exp_tid;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // One record per cycle; sready checked before the edge, outputs after.
    vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[5]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[6]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[7]  = '{4'b1111, 4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[8]  = '{4'b1111, 4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[9]  = '{4'b1111, 4'b1011, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[10] = '{4'b1111, 4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[11] = '{4'b1111, 4'b1011, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[12] = '{4'b1111, 4'b1011, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[13] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[14] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[15] = '{4'b0011, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[16] = '{4'b0011, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[17] = '{4'b0011, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};

    tuser_pat = 4'b1010;
    for (int i = 0; i < NCH; i++) s_tdata[i*64 +: 64] = ch_data(i);
    s_tuser   = tuser_pat;
    s_tvalid  = 4'b1111;
    ch_en     = 4'b1111;
    m_tready  = 1'b1;
    cnt_clear = 1'b0;
    w_tdata   = {64'hBBBB_0000_0000_0001, 64'hAAAA_0000_0000_0000};
    w_tuser   = 2'b00;
    w_tvalid  = 2'b00;
    w_en      = 2'b11;
    w_clear   = 1'b0;
    w_mready  = 1'b1;
    areset    = 1'b1;

    // Reset state with all channels requesting
    @(posedge clk); @(posedge clk); #1;
    chk("rst mvalid", 64'(m_tvalid), 64'd0);
    chk("rst mtdata", m_tdata, 64'd0);
    chk("rst mtuser", 64'(m_tuser), 64'd0);
    chk("rst mtid",   64'(m_tid), 64'd0);
    chk("rst mtlast", 64'(m_tlast), 64'd0);
    chk("rst sready", 64'(s_tready), 64'd0);
    chk("rst evcnt",  ev_count[127:64], 64'd0);
    chk("rst evcnt_lo", ev_count[63:0], 64'd0);

    @(negedge clk);
    s_tvalid = 4'b0000;
    areset   = 1'b0;

    // Table-driven vectors
    for (int v = 0; v < 18; v++) begin
      @(negedge clk);
      s_tvalid = vecs[v].valid;
      ch_en    = vecs[v].en;
      m_tready = vecs[v].mready;
      #1;
      chk($sformatf("v%0d sready", v), 64'(s_tready), 64'(vecs[v].exp_sready));
      @(posedge clk); #1;
      chk($sformatf("v%0d mvalid", v), 64'(m_tvalid), 64'(vecs[v].exp_mvalid));
      chk($sformatf("v%0d mtlast", v), 64'(m_tlast), 64'(vecs[v].exp_mvalid));
      if (vecs[v].exp_mvalid) begin
        chk($sformatf("v%0d mtid", v), 64'(m_tid), 64'(vecs[v].exp_tid));
        chk($sformatf("v%0d mtdata", v), m_tdata, ch_data(int'(vecs[v].exp_tid)));
        chk($sformatf("v%0d mtuser", v), 64'(m_tuser), 64'(tuser_pat[vecs[v].exp_tid]));
      end
    end
    chk("tbl cnt0", 64'(cnt_of(0)), 64'd4);
    chk("tbl cnt1", 64'(cnt_of(1)), 64'd3);
    chk("tbl cnt2 masked", 64'(cnt_of(2)), 64'd2);
    chk("tbl cnt3", 64'(cnt_of(3)), 64'd3);

    // Lone ch2 beat with specific payload
    @(negedge clk);
    s_tdata[2*64 +: 64] = 64'h0000_0001_0000_00FF;
    s_tuser  = 4'b0100;
    s_tvalid = 4'b0100;
    ch_en    = 4'b1111;
    m_tready = 1'b1;
    #1 chk("ch2 sready", 64'(s_tready), 64'b0100);
    @(posedge clk); #1;
    chk("ch2 mvalid", 64'(m_tvalid), 64'd1);
    chk("ch2 mtid",   64'(m_tid), 64'd2);
    chk("ch2 mtuser", 64'(m_tuser), 64'd1);
    chk("ch2 mtlast", 64'(m_tlast), 64'd1);
    chk("ch2 mtdata", m_tdata, 64'h0000_0001_0000_00FF);
    @(negedge clk);
    s_tdata[2*64 +: 64] = ch_data(2);
    s_tuser  = tuser_pat;
    s_tvalid = 4'b0000;
    @(posedge clk); #1;
    chk("ch2 drain", 64'(m_tvalid), 64'd0);

    // Stall: FULL with m_tready low for 5 cycles, then release once
    @(negedge clk);
    s_tvalid = 4'b0010;
    m_tready = 1'b0;
    n_deliv  = 0;
    @(posedge clk); #1;
    chk("stall load tid", 64'(m_tid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      s_tvalid = 4'b1111;
      #1 chk($sformatf("stall%0d sready", c), 64'(s_tready), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d mvalid", c), 64'(m_tvalid), 64'd1);
      chk($sformatf("stall%0d mtid", c), 64'(m_tid), 64'd1);
      chk($sformatf("stall%0d mtdata", c), m_tdata, ch_data(1));
    end
    @(negedge clk);
    s_tvalid = 4'b0000;
    m_tready = 1'b1;
    @(posedge clk); #1;
    chk("stall release", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;
    chk("stall deliveries", 64'(n_deliv), 64'd1);
    chk("stall cnt1", 64'(cnt_of(1)), 64'd4);

    // Clear coinciding with an accept
    @(negedge clk);
    s_tvalid  = 4'b0001;
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    chk("clr accept cnt", ev_count[127:64] | ev_count[63:0], 64'd0);
    chk("clr accept mtid", 64'(m_tid), 64'd0);
    @(negedge clk);
    cnt_clear = 1'b0;
    @(posedge clk); #1;
    chk("post clr cnt0", 64'(cnt_of(0)), 64'd1);

    // Reset while FULL
    @(negedge clk);
    s_tvalid = 4'b0000;
    @(negedge clk);
    s_tvalid = 4'b1000;
    m_tready = 1'b0;
    @(posedge clk); #1;
    chk("pre rst mtid", 64'(m_tid), 64'd3);
    @(negedge clk);
    s_tvalid = 4'b1111;
    areset   = 1'b1;
    #1;
    chk("midrst mvalid", 64'(m_tvalid), 64'd0);
    chk("midrst mtdata", m_tdata, 64'd0);
    chk("midrst sready", 64'(s_tready), 64'd0);
    @(negedge clk);
    areset   = 1'b0;
    m_tready = 1'b1;
    #1 chk("postrst sready", 64'(s_tready), 64'b0001);
    @(posedge clk); #1;
    chk("postrst mtid", 64'(m_tid), 64'd0);
    chk("postrst mvalid", 64'(m_tvalid), 64'd1);
    @(negedge clk);
    s_tvalid = 4'b0000;

    // Counter wrap on the narrow instance
    @(negedge clk);
    w_tvalid = 2'b01;
    for (int k = 0; k < 15; k++) @(posedge clk);
    #1 chk("wrap all ones", 64'(w_count[3:0]), 64'hF);
    @(posedge clk); #1;
    chk("wrap to zero", 64'(w_count[3:0]), 64'd0);
    @(posedge clk); #1;
    chk("wrap plus one", 64'(w_count[3:0]), 64'd1);
    @(negedge clk);
    w_clear = 1'b1;
    @(posedge clk); #1;
    chk("wrap clr wins", 64'(w_count[3:0]), 64'd0);
    chk("wrap ch1 idle", 64'(w_count[7:4]), 64'd0);
    @(negedge clk);
    w_clear  = 1'b0;
    w_tvalid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
